// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data-memory bus between the pipeline and the responder.
//   master (pipeline) : drives MemReadM, MemWriteM, Funct3M, ALUResultM, WriteDataM
//                       and receives RD, StallM, MisalignM
//   slave  (responder): the mirror image
interface dmem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] RD;
    logic        StallM;
    logic        MisalignM;

    modport master (
        output MemReadM, MemWriteM, Funct3M, ALUResultM, WriteDataM,
        input  RD, StallM, MisalignM
    );

    modport slave (
        input  MemReadM, MemWriteM, Funct3M, ALUResultM, WriteDataM,
        output RD, StallM, MisalignM
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder for the MEM stage.
//   Serves byte/half/word loads (sign/zero extended) and byte-enable stores, flags
//   misaligned or illegal accesses, and optionally inserts WAIT_STATES cycles per access
//   while holding the pipeline through StallM.
// Ports:
//   CLK  in  clock, all state on posedge
//   RST  in  asynchronous active-high reset
//   bus  slave modport of dmem_responder_if (request in, RD/StallM/MisalignM out)
// Parameters:
//   DEPTH_WORDS  words of storage, word index = address[31:2] mod DEPTH_WORDS (>= 2)
//   WAIT_STATES  extra cycles per access (0..15), 0 = single-cycle combinational memory
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            CLK,
    input  logic            RST,
    dmem_responder_if.slave bus
);
    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef struct packed {
        logic        isStore;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [3:0][7:0] mem [DEPTH_WORDS];

    state_t          state, stateNext;
    logic [3:0]      cnt, cntNext;
    req_t            curReq, latReq, act;
    logic            reqIn, actValid, stall;
    logic            bad, wrEn;
    logic [IDX_W-1:0] idx;
    logic [3:0][7:0] word, wdLanes;
    logic [7:0]      byteSel;
    logic [15:0]     halfSel;
    logic [3:0]      be;
    logic [31:0]     fmt;

    // Both strobes high is a store.
    assign reqIn  = bus.MemReadM | bus.MemWriteM;
    assign curReq = '{isStore: bus.MemWriteM, funct3: bus.Funct3M,
                      addr: bus.ALUResultM, wdata: bus.WriteDataM};

    function automatic logic badAccess(input logic isStore, input logic [2:0] f3,
                                       input logic [1:0] a);
        case (f3)
            3'b000:  badAccess = 1'b0;
            3'b001:  badAccess = a[0];
            3'b010:  badAccess = |a;
            3'b100:  badAccess = isStore;          // no unsigned store forms
            3'b101:  badAccess = isStore | a[0];
            default: badAccess = 1'b1;
        endcase
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            latReq <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (state == S_IDLE && reqIn)
                latReq <= curReq;
        end
    end

    // ---------------- FSM: next state ----------------
    // Counter is loaded with N-1 in cycle 0 and reaches 0 as DONE is entered, so
    // StallM covers exactly cycles 0..N-1.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (WAIT_STATES == 0) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (reqIn) begin
                    cntNext   = CNT_LOAD;
                    stateNext = (CNT_LOAD == 4'd0) ? S_DONE : S_WAIT;
                end
                S_WAIT: if (!reqIn) begin
                    // pipeline flushed the access: abandon it, nothing is written
                    stateNext = S_IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - 4'd1;
                    if (cnt == 4'd1)
                        stateNext = S_DONE;
                end
                // a request seen in DONE is the same access; the pipeline advances now
                S_DONE:  stateNext = S_IDLE;
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / active request select ----------------
    always_comb begin
        act      = curReq;
        actValid = reqIn;
        stall    = 1'b0;
        if (WAIT_STATES != 0) begin
            act      = latReq;
            actValid = (state == S_DONE);
            stall    = (state == S_IDLE && reqIn) || (state == S_WAIT);
        end
    end

    // ---------------- datapath ----------------
    assign idx     = IDX_W'({2'b00, act.addr[31:2]} % 32'(DEPTH_WORDS));
    assign word    = mem[idx];
    assign byteSel = word[act.addr[1:0]];
    assign halfSel = act.addr[1] ? {word[3], word[2]} : {word[1], word[0]};
    assign bad     = badAccess(act.isStore, act.funct3, act.addr[1:0]);

    always_comb begin
        case (act.funct3[1:0])
            2'b00:   fmt = {{24{~act.funct3[2] & byteSel[7]}}, byteSel};
            2'b01:   fmt = {{16{~act.funct3[2] & halfSel[15]}}, halfSel};
            default: fmt = word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the live ones.
    always_comb begin
        case (act.funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << act.addr[1:0];
                wdLanes = {4{act.wdata[7:0]}};
            end
            2'b01: begin
                be      = act.addr[1] ? 4'b1100 : 4'b0011;
                wdLanes = {2{act.wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wdLanes = act.wdata;
            end
        endcase
    end

    assign wrEn = actValid & act.isStore & ~bad & ~RST;

    always_ff @(posedge CLK) begin
        if (wrEn)
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[idx][b] <= wdLanes[b];
    end

    assign bus.StallM    = stall & ~RST;
    assign bus.MisalignM = actValid & bad & ~RST;
    assign bus.RD        = (actValid & ~act.isStore & ~bad & ~RST) ? fmt : 32'd0;
endmodule
